// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the CPU load/store path and a debug/loader
// port. One requester is granted at a time, with round-robin on ties. The block
// drives the RAM strobes, waits out the RAM read latency, and then returns the
// read data with a one-cycle ack to the granted port.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1      // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              ram_rden_q, ram_rden_d;
    logic              ram_wren_q, ram_wren_d;
    logic              busy_q, busy_d;
    logic              grant_dbg;

    // Next-state logic: arbitration, command latching, latency countdown and
    // read capture. Every output is precomputed from the next state so that it
    // comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        grant_dbg    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant_dbg    = dbg_req && (!cpu_req || !last_owner_q);
                    owner_d      = grant_dbg;
                    last_owner_d = grant_dbg;
                    we_d         = grant_dbg ? dbg_we    : cpu_we;
                    addr_d       = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d      = grant_dbg ? dbg_wdata : cpu_wdata;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (owner_q) begin
                        dbg_rdata_d = ram_q;
                    end else begin
                        cpu_rdata_d = ram_q;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ram_wren_d = (state_d == ISSUE) &&  we_d;
        ram_rden_d = (state_d == ISSUE) && !we_d;
        cpu_ack_d  = (state_d == ACK)   && !owner_d;
        dbg_ack_d  = (state_d == ACK)   &&  owner_d;
        busy_d     = (state_d != IDLE);
    end

    // State and output registers. Reset drops any in-flight transaction and
    // leaves the debug port as last owner so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            ram_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            ram_rden_q   <= ram_rden_d;
            ram_wren_q   <= ram_wren_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_address = addr_q;
    assign ram_data    = wdata_q;
    assign ram_rden    = ram_rden_q;
    assign ram_wren    = ram_wren_q;
    assign cpu_ack     = cpu_ack_q;
    assign dbg_ack     = dbg_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign busy        = busy_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances are built: dut0 with a
// one-cycle RAM read latency and dut1 with a three-cycle latency. Each has a
// behavioural RAM behind it. Expected acks are queued when a request is issued
// and are retired by a monitor process that watches the ack outputs.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef struct {
        int          dut;
        int          port;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t        exp_q[$];
    logic [31:0] mem_model [2][512];
    logic [31:0] rd_model  [2][2];
    int          chk_addr  [10] = '{'h000, 'h001, 'h002, 'h003, 'h100,
                                    'h101, 'h102, 'h103, 'h012, 'h1FF};

    logic              cpu_req     [2];
    logic              cpu_we      [2];
    logic [ADDR_W-1:0] cpu_addr    [2];
    logic [DATA_W-1:0] cpu_wdata   [2];
    logic              cpu_ack     [2];
    logic [DATA_W-1:0] cpu_rdata   [2];
    logic              dbg_req     [2];
    logic              dbg_we      [2];
    logic [ADDR_W-1:0] dbg_addr    [2];
    logic [DATA_W-1:0] dbg_wdata   [2];
    logic              dbg_ack     [2];
    logic [DATA_W-1:0] dbg_rdata   [2];
    logic [ADDR_W-1:0] ram_address [2];
    logic [DATA_W-1:0] ram_data    [2];
    logic              ram_rden    [2];
    logic              ram_wren    [2];
    logic              busy        [2];
    logic              owner       [2];
    logic [DATA_W-1:0] ram_q0, ram_q1, q1a, q1b, q1c;
    logic [DATA_W-1:0] ram0 [512];
    logic [DATA_W-1:0] ram1 [512];

    always #5 clk = ~clk;

    // Free-running cycle count used to time-stamp expected acks.
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]),
        .dbg_wdata(dbg_wdata[0]), .dbg_ack(dbg_ack[0]), .dbg_rdata(dbg_rdata[0]),
        .ram_address(ram_address[0]), .ram_data(ram_data[0]),
        .ram_rden(ram_rden[0]), .ram_wren(ram_wren[0]), .ram_q(ram_q0),
        .busy(busy[0]), .owner(owner[0])
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]),
        .dbg_wdata(dbg_wdata[1]), .dbg_ack(dbg_ack[1]), .dbg_rdata(dbg_rdata[1]),
        .ram_address(ram_address[1]), .ram_data(ram_data[1]),
        .ram_rden(ram_rden[1]), .ram_wren(ram_wren[1]), .ram_q(ram_q1),
        .busy(busy[1]), .owner(owner[1])
    );

    // RAM behind dut0: one registered read stage.
    always @(posedge clk) begin
        if (ram_wren[0]) ram0[ram_address[0]] <= ram_data[0];
        if (ram_rden[0]) ram_q0 <= ram0[ram_address[0]];
    end

    // RAM behind dut1: three read stages, so data appears three edges after the strobe.
    always @(posedge clk) begin
        if (ram_wren[1]) ram1[ram_address[1]] <= ram_data[1];
        if (ram_rden[1]) q1a <= ram1[ram_address[1]];
        q1b <= q1a;
        q1c <= q1b;
    end
    assign ram_q1 = q1c;

    function automatic logic [127:0] all_out(input int d);
        return 128'({cpu_ack[d], cpu_rdata[d], dbg_ack[d], dbg_rdata[d], ram_address[d],
                     ram_data[d], ram_rden[d], ram_wren[d], busy[d], owner[d]});
    endfunction

    function automatic logic ack_of(input int d, input int p);
        return (p != 0) ? dbg_ack[d] : cpu_ack[d];
    endfunction

    function automatic logic [31:0] rdata_of(input int d, input int p);
        return (p != 0) ? dbg_rdata[d] : cpu_rdata[d];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic driveReq(input int d, input int p, input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (p == 0) begin
            cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = data;
        end else begin
            dbg_req[d] = req; dbg_we[d] = we; dbg_addr[d] = addr; dbg_wdata[d] = data;
        end
    endtask

    task automatic processAck(input int d, input int p);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].dut == d && exp_q[i].port == p) idx = i;
        if (idx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: dut%0d port%0d acked at cycle %0d, expected no ack", d, p, cyc);
            return;
        end
        checkOutput("ack_cycle", cyc, exp_q[idx].cyc);
        checkOutput("ack_owner", owner[d], p);
        if (exp_q[idx].rd) begin
            checkOutput("read_data", rdata_of(d, p), exp_q[idx].data);
            rd_model[d][p] = exp_q[idx].data;
        end else begin
            checkOutput("rdata_kept_on_write", rdata_of(d, p), rd_model[d][p]);
        end
        checkOutput("other_rdata_kept", rdata_of(d, 1 - p), rd_model[d][1 - p]);
        exp_q.delete(idx);
    endtask

    task automatic monitorLoop();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) rd_model[d][p] = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 2; d++)
                    for (int p = 0; p < 2; p++) rd_model[d][p] = 32'h0;
            end
            for (int d = 0; d < 2; d++) begin
                if (cpu_ack[d] && dbg_ack[d]) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL both_acks: dut%0d cpu_ack=1 dbg_ack=1, expected at most one", d);
                end
                if (ram_rden[d] && ram_wren[d]) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL both_strobes: dut%0d rden=1 wren=1, expected at most one", d);
                end
                for (int p = 0; p < 2; p++)
                    if (ack_of(d, p)) processAck(d, p);
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL missing_ack: dut%0d port%0d no ack by cycle %0d, expected at cycle %0d",
                             exp_q[i].dut, exp_q[i].port, cyc, exp_q[i].cyc);
                    exp_q.delete(i);
                end
            end
        end
    endtask

    // One transaction on one port. With hold=0 the request is dropped right
    // after the grant and the command lines are scrambled.
    task automatic applyStimulus(input int d, input int p, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                 input bit hold);
        int lat;
        int s;
        int a;
        logic [31:0] rexp;
        lat  = (d == 0) ? 1 : 3;
        rexp = we ? 32'h0 : mem_model[d][addr];
        if (we) mem_model[d][addr] = data;
        @(posedge clk); #1;
        driveReq(d, p, 1'b1, we, addr, data);
        @(posedge clk); #1;
        s = cyc;
        a = we ? s + 1 : s + 1 + lat;
        exp_q.push_back('{dut: d, port: p, rd: !we, data: rexp, cyc: a});
        if (!hold) driveReq(d, p, 1'b0, 1'($urandom), 9'($urandom), $urandom);
        @(negedge clk);
        checkOutput("issue_wren", ram_wren[d], we);
        checkOutput("issue_rden", ram_rden[d], !we);
        checkOutput("issue_addr", ram_address[d], addr);
        if (we) checkOutput("issue_data", ram_data[d], data);
        checkOutput("issue_busy", busy[d], 1'b1);
        checkOutput("issue_owner", owner[d], p);
        @(negedge clk);
        checkOutput("strobes_after_issue", {ram_rden[d], ram_wren[d]}, 2'b00);
        if (!we) checkOutput("wait_addr_held", ram_address[d], addr);
        while (cyc < a + 1) begin
            @(posedge clk); #1;
        end
        driveReq(d, p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        for (int d = 0; d < 2; d++) begin
            driveReq(d, 0, 1'b0, 1'b0, '0, '0);
            driveReq(d, 1, 1'b0, 1'b0, '0, '0);
        end
        fork
            monitorLoop();
        join_none

        // Reset held with random inputs, then idle after release
        $display("[TB] reset with random inputs");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                driveReq(d, 0, 1'($urandom), 1'($urandom), 9'($urandom), $urandom);
                driveReq(d, 1, 1'($urandom), 1'($urandom), 9'($urandom), $urandom);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) checkOutput("reset_outputs", all_out(d), '0);
        end
        for (int d = 0; d < 2; d++) begin
            driveReq(d, 0, 1'b0, 1'b0, '0, '0);
            driveReq(d, 1, 1'b0, 1'b0, '0, '0);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", busy[0], 1'b0);
        end

        // Single-port writes and reads, including the top address
        $display("[TB] cpu/dbg write and read");
        applyStimulus(0, 0, 1'b1, 9'h012, 32'hDEADBEEF, 1'b1);
        applyStimulus(0, 0, 1'b0, 9'h012, 32'h0, 1'b0);
        applyStimulus(0, 0, 1'b1, 9'h1FF, 32'h13579BDF, 1'b0);
        applyStimulus(0, 1, 1'b0, 9'h1FF, 32'h0, 1'b1);

        // Both requesters held high: grants alternate cpu, dbg, cpu, dbg
        $display("[TB] round robin");
        @(posedge clk); #1;
        driveReq(0, 0, 1'b1, 1'b1, 9'h100, 32'h11111111);
        driveReq(0, 1, 1'b1, 1'b1, 9'h101, 32'h22222222);
        @(posedge clk); #1;
        s = cyc;
        mem_model[0][9'h100] = 32'h11111111;
        mem_model[0][9'h101] = 32'h22222222;
        mem_model[0][9'h102] = 32'h33333333;
        mem_model[0][9'h103] = 32'h44444444;
        exp_q.push_back('{dut: 0, port: 0, rd: 1'b0, data: 32'h0, cyc: s + 1});
        exp_q.push_back('{dut: 0, port: 1, rd: 1'b0, data: 32'h0, cyc: s + 4});
        exp_q.push_back('{dut: 0, port: 0, rd: 1'b0, data: 32'h0, cyc: s + 7});
        exp_q.push_back('{dut: 0, port: 1, rd: 1'b0, data: 32'h0, cyc: s + 10});
        driveReq(0, 0, 1'b1, 1'b1, 9'h102, 32'h33333333);
        repeat (3) @(posedge clk);
        #1;
        driveReq(0, 1, 1'b1, 1'b1, 9'h103, 32'h44444444);
        repeat (6) @(posedge clk);
        #1;
        driveReq(0, 0, 1'b0, 1'b0, '0, '0);
        driveReq(0, 1, 1'b0, 1'b0, '0, '0);
        while (cyc < s + 12) begin
            @(posedge clk); #1;
        end

        // Debug port held high for four back-to-back writes
        $display("[TB] back-to-back debug writes");
        @(posedge clk); #1;
        driveReq(0, 1, 1'b1, 1'b1, 9'h000, 32'hC0DE0000);
        @(posedge clk);
        #1;
        s = cyc;
        for (int k = 0; k < 4; k++) begin
            mem_model[0][k] = 32'hC0DE0000 | k;
            exp_q.push_back('{dut: 0, port: 1, rd: 1'b0, data: 32'h0, cyc: s + 3 * k + 1});
            if (k < 3) begin
                driveReq(0, 1, 1'b1, 1'b1, 9'(k + 1), 32'hC0DE0000 | (k + 1));
                repeat (3) @(posedge clk);
                #1;
            end else begin
                driveReq(0, 1, 1'b0, 1'b0, '0, '0);
            end
        end
        while (cyc < s + 13) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++)
            checkOutput("ram_contents", ram0[chk_addr[i]], mem_model[0][chk_addr[i]]);

        // Reset during the wait phase of a cpu read
        $display("[TB] reset during read");
        @(posedge clk); #1;
        driveReq(0, 0, 1'b1, 1'b0, 9'h012, '0);
        @(posedge clk); #1;
        driveReq(0, 0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_mid_read", all_out(0), '0);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("busy_after_reset", busy[0], 1'b0);
        end
        applyStimulus(0, 1, 1'b0, 9'h012, 32'h0, 1'b1);

        // Three-cycle RAM latency instance
        $display("[TB] long read latency");
        applyStimulus(1, 0, 1'b1, 9'h020, 32'h0000A5A5, 1'b1);
        applyStimulus(1, 0, 1'b1, 9'h021, 32'h5A5A0000, 1'b0);
        applyStimulus(1, 0, 1'b0, 9'h021, 32'h0, 1'b1);
        applyStimulus(1, 1, 1'b0, 9'h020, 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL leftover_ack: dut%0d port%0d never acked, expected at cycle %0d",
                     exp_q[0].dut, exp_q[0].port, exp_q[0].cyc);
            exp_q.delete(0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
